pau_op_scheduler: RTL and testbench
===================================

Name: pau_op_scheduler

Overview:
- Control-only issue scheduler in front of the posit arithmetic unit (PAU).
- Accepts one posit operation per cycle from the issue stage.
- Steers each op to one of two groups:
  - the fixed-latency pipelined group: add, sub, mul, conversions, moves, quire ops;
  - the iterative div/sqrt unit.
- Tracks in-flight ops, enforces quire read-after-write ordering, and arbitrates the single writeback port.

Parameters:
- PIPE_LAT, 3: latency of the pipelined group in cycles; must be ≥1.
- TRANS_ID_BITS, 3: width of the transaction tag.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- flush_i  in  1  kill all in-flight work
- op_valid_i  in  1  operation offered
- op_ready_o  out  1  operation accepted when valid&ready
- op_i  in  5  pau_pkg::operation_e
- trans_id_i  in  TRANS_ID_BITS  tag of offered op
- pipe_issue_o  out  1  start strobe to pipelined group
- div_start_o  out  1  start strobe to iterative unit
- div_sqrt_o  out  1  0 = PDIV, 1 = PSQRT; valid with div_start_o
- div_kill_o  out  1  abort iterative unit
- div_done_i  in  1  iterative result ready (single-cycle pulse)
- result_valid_o  out  1  writeback strobe
- result_trans_id_o  out  TRANS_ID_BITS  tag of written result
- result_src_o  out  1  0 = pipelined, 1 = iterative
- result_illegal_o  out  1  op was illegal; no result data
- busy_o  out  1  any op in flight or held

Behaviour:
- Reset values: all outputs 0. Shadow pipe invalid. FSM = IDLE.
- Op classes:
  - ITER = {PDIV, PSQRT}.
  - QWR = {QMADD, QMSUB, QCLR, QNEG}.
  - QRD = {QROUND}.
  - Encodings 23..31 are ILLEGAL.
  - All other defined ops are PIPE.
- op_ready_o depends combinationally on op_i and is forced to 0 while flush_i=1.
  - ITER: ready iff FSM=IDLE.
  - PIPE/QWR/ILLEGAL: ready iff FSM≠HOLD.
  - QRD: ready iff FSM≠HOLD and no valid QWR entry in shadow stages s1..sPIPE_LAT.
- Shadow pipe:
  - An op accepted in cycle t is tracked by a shadow entry {valid, trans_id, qwr, illegal}.
  - The entry occupies s1 at t+1 … sPIPE_LAT at t+PIPE_LAT.
  - result_valid_o is driven combinationally from sPIPE_LAT in cycle t+PIPE_LAT; result_src_o=0.
  - pipe_issue_o = accept & (PIPE|QWR|QRD), asserted in cycle t. ILLEGAL ops get no pipe_issue_o.
  - The shadow pipe never stalls.
- Iterative FSM:
  - IDLE --accept ITER--> BUSY. div_start_o and div_sqrt_o asserted in the accept cycle; tag latched.
  - BUSY --div_done_i & sPIPE_LAT invalid--> IDLE. result_valid_o in the same cycle, result_src_o=1.
  - BUSY --div_done_i & sPIPE_LAT valid--> HOLD. The pipelined result wins the port.
  - HOLD --sPIPE_LAT invalid--> IDLE. The held result is written that cycle.
    - HOLD blocks all accepts, so a bubble reaches sPIPE_LAT within PIPE_LAT cycles.
- div_done_i outside BUSY is ignored.
- flush_i:
  - Next edge clears all shadow entries; FSM → IDLE.
  - div_kill_o pulses in the flush cycle iff FSM=BUSY.
  - No result_valid_o is asserted in the flush cycle.
  - A held HOLD result is discarded.
- Asynchronous reset mid-operation gives the same end state as flush, with no div_kill_o.
- busy_o = any shadow entry valid | FSM≠IDLE.

Optional Feature:
- PAU_QUIRE_EN defined:
  - Quire ops are handled as above.
- PAU_QUIRE_EN undefined:
  - QWR and QRD are classified ILLEGAL: accepted, no pipe_issue_o.
  - They complete after PIPE_LAT cycles with result_illegal_o=1.
  - Quire hazard logic and the qwr shadow bit are removed.

Decomposition:
- pau_pkg:
  - operation_e with OP_BITS = 5.
  - pau_sched_entry_t {valid, trans_id, qwr, illegal}.
  - Functions is_iter(op), is_quire_wr(op), is_quire_rd(op), is_legal(op).
- Sub-module pau_sched_shadow_pipe:
  - PIPE_LAT-deep entry shift register with flush.
  - Exports the tail entry and an any-qwr flag.

Test Plan (PIPE_LAT=3):
- PADD id=1 at cycle 0 → pipe_issue_o at cycle 0; result_valid_o, id=1, src=0 at cycle 3; busy_o low at cycle 4.
- PDIV id=2 at cycle 0; div_done_i at cycle 10 → div_start_o=1 and div_sqrt_o=0 at cycle 0. PSQRT offered at cycles 1–10 sees ready=0. result id=2, src=1 at cycle 10. PSQRT accepted at cycle 11.
- PDIV id=2 at cycle 0; PMUL id=3 at cycle 7; div_done_i at cycle 10 → cycle 10 writes id=3 with FSM→HOLD; op_ready_o=0 at cycle 11; cycle 11 writes id=2, src=1.
- QMADD id=4 at cycle 0; QROUND id=5 offered from cycle 1 → ready=0 at cycles 1–3; accepted at cycle 4; results at cycles 3 and 7.
- PSQRT at cycle 0 plus PADD at cycle 1; flush_i at cycle 2 → div_kill_o at cycle 2; no result_valid_o ever for either op; busy_o=0 at cycle 3.
- Op encoding 25 id=6 at cycle 0 → no pipe_issue_o; at cycle 3 result_valid_o=1 with result_illegal_o=1. With PAU_QUIRE_EN undefined, QCLR behaves the same way.

Source files
------------

// File: rtl/pau_pkg.sv
// Shared op encodings, scheduler entry type and op classification for the PAU issue scheduler.
// Build option PAU_QUIRE_EN: when undefined, quire ops are classified illegal and the qwr entry bit is dropped.
package pau_pkg;

    localparam int OP_BITS           = 5;
    localparam int MAX_TRANS_ID_BITS = 8;

    typedef enum logic [OP_BITS-1:0] {
        PADD     = 5'd0,
        PSUB     = 5'd1,
        PMUL     = 5'd2,
        PDIV     = 5'd3,
        PSQRT    = 5'd4,
        PMIN     = 5'd5,
        PMAX     = 5'd6,
        PSGNJ    = 5'd7,
        PSGNJN   = 5'd8,
        PEQ      = 5'd9,
        PLT      = 5'd10,
        PLE      = 5'd11,
        PCLASS   = 5'd12,
        PCVT_P2I = 5'd13,
        PCVT_P2U = 5'd14,
        PCVT_I2P = 5'd15,
        PCVT_U2P = 5'd16,
        PMV      = 5'd17,
        QMADD    = 5'd18,
        QMSUB    = 5'd19,
        QCLR     = 5'd20,
        QNEG     = 5'd21,
        QROUND   = 5'd22
    } operation_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } sched_state_e;

    // Tag field is sized for the widest supported tag; narrower builds leave the top bits zero.
    typedef struct packed {
        logic                         valid;
        logic [MAX_TRANS_ID_BITS-1:0] transId;
`ifdef PAU_QUIRE_EN
        logic                         qwr;
`endif
        logic                         illegal;
    } pau_sched_entry_t;

    function automatic logic is_iter(input logic [OP_BITS-1:0] op);
        return (op == PDIV) || (op == PSQRT);
    endfunction

    function automatic logic is_quire_wr(input logic [OP_BITS-1:0] op);
        return (op == QMADD) || (op == QMSUB) || (op == QCLR) || (op == QNEG);
    endfunction

    function automatic logic is_quire_rd(input logic [OP_BITS-1:0] op);
        return (op == QROUND);
    endfunction

    function automatic logic is_legal(input logic [OP_BITS-1:0] op);
`ifdef PAU_QUIRE_EN
        return (op <= QROUND);
`else
        return (op <= QROUND) && !is_quire_wr(op) && !is_quire_rd(op);
`endif
    endfunction

endpackage

// File: rtl/pau_sched_shadow_pipe.sv
// Never-stalling shadow of the pipelined group: one entry per stage, cleared by flush.
// Build option PAU_QUIRE_EN adds the any-quire-write flag used for quire read ordering.
module pau_sched_shadow_pipe
    import pau_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  pau_sched_entry_t inEntry,
    output pau_sched_entry_t tailEntry,
    output logic             anyValid
`ifdef PAU_QUIRE_EN
    ,
    output logic             anyQwr
`endif
);

    pau_sched_entry_t stages [PIPE_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE_LAT; i++) stages[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < PIPE_LAT; i++) stages[i] <= '0;
        end else begin
            stages[0] <= inEntry.valid ? inEntry : '0;
            for (int i = 1; i < PIPE_LAT; i++) stages[i] <= stages[i-1];
        end
    end

    assign tailEntry = stages[PIPE_LAT-1];

    always_comb begin
        anyValid = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) anyValid = anyValid | stages[i].valid;
    end

`ifdef PAU_QUIRE_EN
    always_comb begin
        anyQwr = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) anyQwr = anyQwr | (stages[i].valid & stages[i].qwr);
    end
`endif

endmodule

// File: rtl/pau_op_scheduler.sv
// Issue scheduler for the PAU: steers ops to the pipelined group or the div/sqrt unit and arbitrates writeback.
// Build option PAU_QUIRE_EN enables quire ops and quire read-after-write ordering.
module pau_op_scheduler
    import pau_pkg::*;
#(
    parameter int PIPE_LAT      = 3,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic [OP_BITS-1:0]       op_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     pipe_issue_o,
    output logic                     div_start_o,
    output logic                     div_sqrt_o,
    output logic                     div_kill_o,
    input  logic                     div_done_i,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic                     result_src_o,
    output logic                     result_illegal_o,
    output logic                     busy_o
);

    sched_state_e             state, stateNext;
    logic [TRANS_ID_BITS-1:0] divTag;
    logic                     legalOp, iterOp, accept, anyValid;
    pau_sched_entry_t         inEntry, tailEntry;
    logic                     unusedTransId;
`ifdef PAU_QUIRE_EN
    logic                     anyQwr, qrdOp;
`endif

    assign legalOp = is_legal(op_i);
    assign iterOp  = legalOp && is_iter(op_i);
`ifdef PAU_QUIRE_EN
    assign qrdOp   = legalOp && is_quire_rd(op_i);
`endif

    // Nothing is accepted during reset or flush; a quire read waits until no quire write is in flight.
    always_comb begin
        op_ready_o = 1'b0;
        if (rst_ni && !flush_i) begin
            if (iterOp) op_ready_o = (state == ST_IDLE);
`ifdef PAU_QUIRE_EN
            else if (qrdOp) op_ready_o = (state != ST_HOLD) && !anyQwr;
`endif
            else op_ready_o = (state != ST_HOLD);
        end
    end

    assign accept       = op_valid_i && op_ready_o;
    assign pipe_issue_o = accept && legalOp && !iterOp;
    assign div_start_o  = accept && iterOp;
    assign div_sqrt_o   = div_start_o && (op_i == PSQRT);

    always_comb begin
        inEntry                               = '0;
        inEntry.valid                         = accept && !iterOp;
        inEntry.transId[TRANS_ID_BITS-1:0]    = trans_id_i;
`ifdef PAU_QUIRE_EN
        inEntry.qwr                           = legalOp && is_quire_wr(op_i);
`endif
        inEntry.illegal                       = !legalOp;
    end

    pau_sched_shadow_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) shadowPipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .inEntry   (inEntry),
        .tailEntry (tailEntry),
        .anyValid  (anyValid)
`ifdef PAU_QUIRE_EN
        ,
        .anyQwr    (anyQwr)
`endif
    );

    assign unusedTransId = ^tailEntry.transId;
    assign busy_o        = anyValid || (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            divTag <= '0;
        end else begin
            state <= stateNext;
            if (div_start_o) divTag <= trans_id_i;
        end
    end

    // The pipelined tail always owns the writeback port; an iterative result finishing under it parks in HOLD.
    always_comb begin
        stateNext         = state;
        div_kill_o        = 1'b0;
        result_valid_o    = 1'b0;
        result_trans_id_o = '0;
        result_src_o      = 1'b0;
        result_illegal_o  = 1'b0;
        if (flush_i) begin
            div_kill_o = (state == ST_BUSY);
            stateNext  = ST_IDLE;
        end else begin
            if (tailEntry.valid) begin
                result_valid_o    = 1'b1;
                result_trans_id_o = tailEntry.transId[TRANS_ID_BITS-1:0];
                result_illegal_o  = tailEntry.illegal;
            end
            unique case (state)
                ST_IDLE: begin
                    if (div_start_o) stateNext = ST_BUSY;
                end
                ST_BUSY: begin
                    if (div_done_i) begin
                        if (tailEntry.valid) begin
                            stateNext = ST_HOLD;
                        end else begin
                            stateNext         = ST_IDLE;
                            result_valid_o    = 1'b1;
                            result_trans_id_o = divTag;
                            result_src_o      = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!tailEntry.valid) begin
                        stateNext         = ST_IDLE;
                        result_valid_o    = 1'b1;
                        result_trans_id_o = divTag;
                        result_src_o      = 1'b1;
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pau_op_scheduler.sv
// Directed bench for pau_op_scheduler with a result scoreboard checked by an independent writeback monitor.
// Quire scenarios follow PAU_QUIRE_EN: hazard ordering when defined, illegal completion otherwise.
module tb_pau_op_scheduler;
    import pau_pkg::*;

    localparam int PIPE_LAT = 3;
    localparam int TIDB     = 3;

    logic            clk = 1'b0;
    logic            rstN, flush, opValid, divDone;
    logic [4:0]      op;
    logic [TIDB-1:0] tid;
    logic            opReady, pipeIssue, divStart, divSqrt, divKill;
    logic            resultValid, resultSrc, resultIllegal, busy;
    logic [TIDB-1:0] resultTid;

    typedef struct {
        logic [TIDB-1:0] tid;
        logic            src;
        logic            illegal;
        int              cycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks   = 0;
    int   errors   = 0;
    int   cycleCnt = 0;
    int   base;

    pau_op_scheduler #(
        .PIPE_LAT      (PIPE_LAT),
        .TRANS_ID_BITS (TIDB)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .flush_i           (flush),
        .op_valid_i        (opValid),
        .op_ready_o        (opReady),
        .op_i              (op),
        .trans_id_i        (tid),
        .pipe_issue_o      (pipeIssue),
        .div_start_o       (divStart),
        .div_sqrt_o        (divSqrt),
        .div_kill_o        (divKill),
        .div_done_i        (divDone),
        .result_valid_o    (resultValid),
        .result_trans_id_o (resultTid),
        .result_src_o      (resultSrc),
        .result_illegal_o  (resultIllegal),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic applyStimulus(input logic v, input logic [4:0] o, input logic [TIDB-1:0] id,
                                 input logic dd, input logic fl);
        opValid = v;
        op      = o;
        tid     = id;
        divDone = dd;
        flush   = fl;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0b, required %0b (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    task automatic pushExp(input logic [TIDB-1:0] id, input logic src, input logic ill, input int cyc);
        expQ.push_back('{tid: id, src: src, illegal: ill, cycle: cyc});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            applyStimulus(1'b0, PADD, 3'd0, 1'b0, 1'b0);
        end
    endtask

    // Every writeback must match the oldest outstanding expectation, including the cycle it appears in.
    always @(negedge clk) begin
        if (rstN && resultValid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected result: got id=%0d src=%0b illegal=%0b at cycle %0d, required no writeback",
                         resultTid, resultSrc, resultIllegal, cycleCnt);
            end else begin
                monExp = expQ.pop_front();
                if (resultTid !== monExp.tid || resultSrc !== monExp.src ||
                    resultIllegal !== monExp.illegal || cycleCnt != monExp.cycle) begin
                    errors++;
                    $display("[TB] FAIL result: got id=%0d src=%0b illegal=%0b cycle=%0d, required id=%0d src=%0b illegal=%0b cycle=%0d",
                             resultTid, resultSrc, resultIllegal, cycleCnt,
                             monExp.tid, monExp.src, monExp.illegal, monExp.cycle);
                end
            end
        end
    end

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b1, PADD, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset op_ready", opReady, 1'b0);
        checkOutput("reset pipe_issue", pipeIssue, 1'b0);
        checkOutput("reset result_valid", resultValid, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        nextCycle();
        rstN = 1'b1;
        applyStimulus(1'b0, PADD, 3'd0, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] PADD through the pipelined group");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, PADD, 3'd1, 1'b0, 1'b0);
        pushExp(3'd1, 1'b0, 1'b0, base + 3);
        #2;
        checkOutput("padd ready", opReady, 1'b1);
        checkOutput("padd pipe_issue", pipeIssue, 1'b1);
        checkOutput("padd div_start", divStart, 1'b0);
        idleCycles(3);
        #2;
        checkOutput("padd busy at c3", busy, 1'b1);
        idleCycles(1);
        #2;
        checkOutput("padd busy at c4", busy, 1'b0);
        idleCycles(2);

        $display("[TB] PDIV then blocked PSQRT");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, PDIV, 3'd2, 1'b0, 1'b0);
        #2;
        checkOutput("pdiv div_start", divStart, 1'b1);
        checkOutput("pdiv div_sqrt", divSqrt, 1'b0);
        checkOutput("pdiv pipe_issue", pipeIssue, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            applyStimulus(1'b1, PSQRT, 3'd7, (c == 10), 1'b0);
            if (c == 10) pushExp(3'd2, 1'b1, 1'b0, base + 10);
            #2;
            checkOutput("psqrt blocked ready", opReady, 1'b0);
        end
        nextCycle();
        applyStimulus(1'b1, PSQRT, 3'd7, 1'b0, 1'b0);
        #2;
        checkOutput("psqrt c11 ready", opReady, 1'b1);
        checkOutput("psqrt c11 div_start", divStart, 1'b1);
        checkOutput("psqrt c11 div_sqrt", divSqrt, 1'b1);
        for (int c = 12; c <= 14; c++) begin
            nextCycle();
            applyStimulus(1'b0, PADD, 3'd0, (c == 14), 1'b0);
            if (c == 14) pushExp(3'd7, 1'b1, 1'b0, base + 14);
        end
        idleCycles(1);
        #2;
        checkOutput("psqrt done busy", busy, 1'b0);
        idleCycles(2);

        $display("[TB] writeback collision parks iterative result");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, PDIV, 3'd2, 1'b0, 1'b0);
        idleCycles(6);
        nextCycle();
        applyStimulus(1'b1, PMUL, 3'd3, 1'b0, 1'b0);
        pushExp(3'd3, 1'b0, 1'b0, base + 10);
        #2;
        checkOutput("pmul under busy ready", opReady, 1'b1);
        idleCycles(2);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b1, 1'b0);
        pushExp(3'd2, 1'b1, 1'b0, base + 11);
        idleCycles(1);
        #2;
        checkOutput("hold ready", opReady, 1'b0);
        idleCycles(1);
        #2;
        checkOutput("hold drained busy", busy, 1'b0);
        idleCycles(2);

`ifdef PAU_QUIRE_EN
        $display("[TB] quire read waits for quire write");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, QMADD, 3'd4, 1'b0, 1'b0);
        pushExp(3'd4, 1'b0, 1'b0, base + 3);
        #2;
        checkOutput("qmadd pipe_issue", pipeIssue, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            applyStimulus(1'b1, QROUND, 3'd5, 1'b0, 1'b0);
            #2;
            checkOutput("qround blocked ready", opReady, 1'b0);
        end
        nextCycle();
        applyStimulus(1'b1, QROUND, 3'd5, 1'b0, 1'b0);
        pushExp(3'd5, 1'b0, 1'b0, base + 7);
        #2;
        checkOutput("qround c4 ready", opReady, 1'b1);
        checkOutput("qround c4 pipe_issue", pipeIssue, 1'b1);
        idleCycles(5);
`else
        $display("[TB] quire ops complete as illegal");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, QCLR, 3'd6, 1'b0, 1'b0);
        pushExp(3'd6, 1'b0, 1'b1, base + 3);
        #2;
        checkOutput("qclr ready", opReady, 1'b1);
        checkOutput("qclr pipe_issue", pipeIssue, 1'b0);
        nextCycle();
        applyStimulus(1'b1, QROUND, 3'd5, 1'b0, 1'b0);
        pushExp(3'd5, 1'b0, 1'b1, base + 4);
        #2;
        checkOutput("qround ready", opReady, 1'b1);
        checkOutput("qround pipe_issue", pipeIssue, 1'b0);
        idleCycles(5);
`endif

        $display("[TB] flush kills in-flight work");
        nextCycle();
        applyStimulus(1'b1, PSQRT, 3'd1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, PADD, 3'd2, 1'b0, 1'b0);
        #2;
        checkOutput("flush padd pipe_issue", pipeIssue, 1'b1);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b0, 1'b1);
        #2;
        checkOutput("flush div_kill", divKill, 1'b1);
        checkOutput("flush ready", opReady, 1'b0);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b0, 1'b0);
        #2;
        checkOutput("post flush busy", busy, 1'b0);
        checkOutput("post flush div_kill", divKill, 1'b0);
        idleCycles(1);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b1, 1'b0);
        idleCycles(4);

        $display("[TB] illegal encoding");
        nextCycle();
        base = cycleCnt;
        applyStimulus(1'b1, 5'd25, 3'd6, 1'b0, 1'b0);
        pushExp(3'd6, 1'b0, 1'b1, base + 3);
        #2;
        checkOutput("illegal ready", opReady, 1'b1);
        checkOutput("illegal pipe_issue", pipeIssue, 1'b0);
        checkOutput("illegal div_start", divStart, 1'b0);
        idleCycles(5);

        $display("[TB] asynchronous reset mid-operation");
        nextCycle();
        applyStimulus(1'b1, PDIV, 3'd3, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, PADD, 3'd4, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b0, 1'b0);
        rstN = 1'b0;
        #2;
        checkOutput("async reset div_kill", divKill, 1'b0);
        checkOutput("async reset busy", busy, 1'b0);
        checkOutput("async reset result_valid", resultValid, 1'b0);
        nextCycle();
        rstN = 1'b1;
        #2;
        checkOutput("after reset busy", busy, 1'b0);
        nextCycle();
        applyStimulus(1'b0, PADD, 3'd0, 1'b1, 1'b0);
        idleCycles(5);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending results, required 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
